alu_iterative: RTL and testbench

- Arithmetic responder on the controller↔ALU interface: accepts operand pair al_A/al_B plus command al_cmd, returns result al_C.
- AD/SB complete in one cycle. MU/DI are iterative: shift-add multiply, restoring divide.
- Signed two's-complement calculator datapath; replaces the combinational ALU so multiply/divide do not set the clock period.
- Adds start/busy/done handshake and an error flag for overflow and divide-by-zero.

---
 rtl/alu_iterative_pkg.sv | 32 +++
 rtl/alu_shift_core.sv | 77 +++++++
 rtl/alu_iterative.sv | 144 ++++++++++++++
 tb/tb_alu_iterative.sv | 204 ++++++++++++++++++++
 4 files changed

// File: rtl/alu_iterative_pkg.sv
// Shared ALU interface constants: command encodings, data width and FSM states.
// Also holds the command sanitiser and the iterative core's mode type.
package alu_iterative_pkg;

   localparam int CD_N = 32;
   localparam logic [CD_N-1:0] CD_0 = '0;

   localparam int AC_N = 3;
   localparam logic [AC_N-1:0] AC_AD = 3'd0;
   localparam logic [AC_N-1:0] AC_SB = 3'd1;
   localparam logic [AC_N-1:0] AC_MU = 3'd2;
   localparam logic [AC_N-1:0] AC_DI = 3'd3;

   localparam logic [1:0] AS_IDLE = 2'd0;
   localparam logic [1:0] AS_ITER = 2'd1;
   localparam logic [1:0] AS_FIX  = 2'd2;
   localparam logic [1:0] AS_DONE = 2'd3;

   typedef enum logic {
      CORE_MUL = 1'b0,
      CORE_DIV = 1'b1
   } core_mode_t;

   // Unrecognised commands fall back to add.
   function automatic logic [AC_N-1:0] cmd_sanitize(input logic [AC_N-1:0] cmd);
      if (cmd == AC_SB || cmd == AC_MU || cmd == AC_DI) begin
         return cmd;
      end
      return AC_AD;
   endfunction

endpackage

// File: rtl/alu_shift_core.sv
// One-bit-per-cycle unsigned datapath: shift-add multiply (LSB first) or
// restoring divide (MSB first) sharing one 2*WIDTH accumulator.
module alu_shift_core
   import alu_iterative_pkg::*;
#(
   parameter int WIDTH = CD_N
) (
   input  logic               Clock,
   input  logic               Reset,
   input  logic               load,
   input  logic               step,
   input  core_mode_t         mode,
   input  logic [WIDTH-1:0]   mag_a,
   input  logic [WIDTH-1:0]   mag_b,
   output logic [2*WIDTH-1:0] product,
   output logic [WIDTH-1:0]   quotient
);

   logic [2*WIDTH-1:0] acc_reg, acc_next;
   logic [WIDTH:0]     rem_reg, rem_next;
   logic [WIDTH-1:0]   opb_reg;
   core_mode_t         mode_reg;

   logic [WIDTH:0]     add_sum;
   logic [WIDTH:0]     rem_shift;
   logic [WIDTH:0]     rem_trial;

   assign product  = acc_reg;
   assign quotient = acc_reg[WIDTH-1:0];

   // Multiply: low half starts as the multiplier and drains as the product grows.
   // Divide: low half starts as the dividend and fills with quotient bits.
   always_comb begin
      acc_next  = acc_reg;
      rem_next  = rem_reg;
      add_sum   = {1'b0, acc_reg[2*WIDTH-1:WIDTH]} + {1'b0, opb_reg};
      rem_shift = {rem_reg[WIDTH-1:0], acc_reg[WIDTH-1]};
      rem_trial = rem_shift - {1'b0, opb_reg};
      if (load) begin
         acc_next = {{WIDTH{1'b0}}, mag_a};
         rem_next = '0;
      end else if (step) begin
         if (mode_reg == CORE_MUL) begin
            if (acc_reg[0]) begin
               acc_next = {add_sum, acc_reg[WIDTH-1:1]};
            end else begin
               acc_next = {1'b0, acc_reg[2*WIDTH-1:1]};
            end
         end else begin
            if (!rem_trial[WIDTH]) begin
               rem_next = rem_trial;
               acc_next = {acc_reg[2*WIDTH-1:WIDTH], acc_reg[WIDTH-2:0], 1'b1};
            end else begin
               rem_next = rem_shift;
               acc_next = {acc_reg[2*WIDTH-1:WIDTH], acc_reg[WIDTH-2:0], 1'b0};
            end
         end
      end
   end

   always_ff @(posedge Clock) begin
      if (!Reset) begin
         acc_reg  <= '0;
         rem_reg  <= '0;
         opb_reg  <= '0;
         mode_reg <= CORE_MUL;
      end else begin
         acc_reg <= acc_next;
         rem_reg <= rem_next;
         if (load) begin
            opb_reg  <= mag_b;
            mode_reg <= mode;
         end
      end
   end

endmodule

// File: rtl/alu_iterative.sv
// Signed ALU with start/busy/done handshake: single-cycle add/subtract,
// iterative multiply/divide through alu_shift_core, overflow and div-by-zero flag.
module alu_iterative
   import alu_iterative_pkg::*;
#(
   parameter int WIDTH = CD_N,
   parameter int CNT_W = 6
) (
   input  logic             Clock,
   input  logic             Reset,
   input  logic             al_start,
   input  logic [WIDTH-1:0] al_A,
   input  logic [WIDTH-1:0] al_B,
   input  logic [AC_N-1:0]  al_cmd,
   output logic [WIDTH-1:0] al_C,
   output logic             al_busy,
   output logic             al_done,
   output logic             al_err
);

   logic [1:0]       state_reg, state_next;
   logic [CNT_W-1:0] cnt_reg, cnt_next;
   logic [AC_N-1:0]  cmd_reg, cmd_next;
   logic             sign_reg, sign_next;
   logic [WIDTH-1:0] c_reg, c_next;
   logic             err_reg, err_next;

   logic [AC_N-1:0]    cmd_in;
   logic [WIDTH-1:0]   sum, diff, mag_a, mag_b;
   logic               add_ovf, sub_ovf;
   logic               core_load, core_step;
   core_mode_t         core_mode;
   logic [2*WIDTH-1:0] prod_mag, prod_signed, half_range;
   logic [WIDTH-1:0]   quo_mag, quo_signed;
   logic               mu_err, di_err;

   alu_shift_core #(.WIDTH(WIDTH)) u_core (
      .Clock    (Clock),
      .Reset    (Reset),
      .load     (core_load),
      .step     (core_step),
      .mode     (core_mode),
      .mag_a    (mag_a),
      .mag_b    (mag_b),
      .product  (prod_mag),
      .quotient (quo_mag)
   );

   assign al_C    = c_reg;
   assign al_err  = err_reg;
   assign al_busy = (state_reg == AS_ITER) || (state_reg == AS_FIX);
   assign al_done = (state_reg == AS_DONE);

   assign cmd_in    = cmd_sanitize(al_cmd);
   assign core_mode = (cmd_in == AC_DI) ? CORE_DIV : CORE_MUL;
   assign sum       = al_A + al_B;
   assign diff      = al_A - al_B;
   assign add_ovf   = (al_A[WIDTH-1] == al_B[WIDTH-1]) && (sum[WIDTH-1] != al_A[WIDTH-1]);
   assign sub_ovf   = (al_A[WIDTH-1] != al_B[WIDTH-1]) && (diff[WIDTH-1] != al_A[WIDTH-1]);
   // Negating MIN yields the same bit pattern, which read unsigned is exactly 2^(WIDTH-1).
   assign mag_a     = al_A[WIDTH-1] ? -al_A : al_A;
   assign mag_b     = al_B[WIDTH-1] ? -al_B : al_B;

   assign half_range  = {{WIDTH{1'b0}}, 1'b1, {(WIDTH-1){1'b0}}};
   assign prod_signed = sign_reg ? -prod_mag : prod_mag;
   assign mu_err      = sign_reg ? (prod_mag > half_range) : (prod_mag >= half_range);
   assign quo_signed  = sign_reg ? -quo_mag : quo_mag;
   assign di_err      = !sign_reg && (quo_mag == half_range[WIDTH-1:0]);

   always_comb begin
      state_next = state_reg;
      cnt_next   = cnt_reg;
      cmd_next   = cmd_reg;
      sign_next  = sign_reg;
      c_next     = c_reg;
      err_next   = err_reg;
      core_load  = 1'b0;
      core_step  = 1'b0;
      case (state_reg)
         AS_IDLE: begin
            if (al_start) begin
               cmd_next = cmd_in;
               if (cmd_in == AC_AD) begin
                  c_next     = sum;
                  err_next   = add_ovf;
                  state_next = AS_DONE;
               end else if (cmd_in == AC_SB) begin
                  c_next     = diff;
                  err_next   = sub_ovf;
                  state_next = AS_DONE;
               end else if (cmd_in == AC_DI && al_B == '0) begin
                  c_next     = '0;
                  err_next   = 1'b1;
                  state_next = AS_DONE;
               end else begin
                  core_load  = 1'b1;
                  sign_next  = al_A[WIDTH-1] ^ al_B[WIDTH-1];
                  cnt_next   = '0;
                  state_next = AS_ITER;
               end
            end
         end
         AS_ITER: begin
            core_step = 1'b1;
            cnt_next  = cnt_reg + 1'b1;
            if (cnt_reg == CNT_W'(WIDTH - 1)) begin
               state_next = AS_FIX;
            end
         end
         AS_FIX: begin
            if (cmd_reg == AC_MU) begin
               c_next   = prod_signed[WIDTH-1:0];
               err_next = mu_err;
            end else begin
               c_next   = quo_signed;
               err_next = di_err;
            end
            state_next = AS_DONE;
         end
         default: begin
            state_next = AS_IDLE;
         end
      endcase
   end

   always_ff @(posedge Clock) begin
      if (!Reset) begin
         state_reg <= AS_IDLE;
         cnt_reg   <= '0;
         cmd_reg   <= AC_AD;
         sign_reg  <= 1'b0;
         c_reg     <= '0;
         err_reg   <= 1'b0;
      end else begin
         state_reg <= state_next;
         cnt_reg   <= cnt_next;
         cmd_reg   <= cmd_next;
         sign_reg  <= sign_next;
         c_reg     <= c_next;
         err_reg   <= err_next;
      end
   end

endmodule

// File: tb/tb_alu_iterative.sv
// Directed and randomized checks of alu_iterative against a plain-arithmetic
// model of signed add/sub/mul/div with overflow and divide-by-zero.
module tb_alu_iterative;
   import alu_iterative_pkg::*;

   localparam int W = CD_N;

   logic            Clock = 1'b0;
   logic            Reset;
   logic            al_start;
   logic [W-1:0]    al_A;
   logic [W-1:0]    al_B;
   logic [AC_N-1:0] al_cmd;
   logic [W-1:0]    al_C;
   logic            al_busy;
   logic            al_done;
   logic            al_err;

   int checks   = 0;
   int failures = 0;

   alu_iterative #(.WIDTH(W), .CNT_W(6)) dut (
      .Clock    (Clock),
      .Reset    (Reset),
      .al_start (al_start),
      .al_A     (al_A),
      .al_B     (al_B),
      .al_cmd   (al_cmd),
      .al_C     (al_C),
      .al_busy  (al_busy),
      .al_done  (al_done),
      .al_err   (al_err)
   );

   always #5 Clock = ~Clock;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Reference: exact signed result in 64 bits, then wrap and range-test.
   function automatic void model(input logic [AC_N-1:0] cmd, input logic [W-1:0] a,
                                 input logic [W-1:0] b, output logic [W-1:0] c,
                                 output logic e, output int lat);
      longint sa, sb, r;
      sa  = longint'($signed(a));
      sb  = longint'($signed(b));
      lat = 1;
      if (cmd == AC_SB) begin
         r = sa - sb;
      end else if (cmd == AC_MU) begin
         r = sa * sb;
         lat = W + 2;
      end else if (cmd == AC_DI) begin
         if (sb == 0) begin
            c = '0;
            e = 1'b1;
            return;
         end
         r = sa / sb;
         lat = W + 2;
      end else begin
         r = sa + sb;
      end
      c = r[W-1:0];
      e = (r > 64'sd2147483647) || (r < -64'sd2147483648);
   endfunction

   task automatic run_op(input string tag, input logic [AC_N-1:0] cmd,
                         input logic [W-1:0] a, input logic [W-1:0] b, input bit garbage);
      logic [W-1:0] ec;
      logic         ee;
      int           elat;
      int           lat;
      int           busy_n;
      lat    = 0;
      busy_n = 0;
      model(cmd, a, b, ec, ee, elat);
      @(negedge Clock);
      al_start = 1'b1;
      al_cmd   = cmd;
      al_A     = a;
      al_B     = b;
      @(posedge Clock);
      #1;
      al_start = 1'b0;
      if (garbage) begin
         al_A   = $urandom;
         al_B   = $urandom;
         al_cmd = AC_N'($urandom);
      end
      for (int n = 1; n <= 40 && lat == 0; n++) begin
         @(negedge Clock);
         if (al_busy) busy_n++;
         if (al_done) lat = n;
      end
      $display("op %s cmd=%0d A=%0h B=%0h -> C=%0h err=%0b done_at=%0d", tag, cmd, a, b, al_C, al_err, lat);
      check({tag, "_lat"}, 64'(lat), 64'(elat));
      check({tag, "_busy"}, 64'(busy_n), 64'(elat - 1));
      check({tag, "_C"}, 64'(al_C), 64'(ec));
      check({tag, "_err"}, 64'(al_err), 64'(ee));
      @(negedge Clock);
      check({tag, "_hold"}, {31'(0), al_done, al_C}, {31'(0), 1'b0, ec});
   endtask

   function automatic logic [W-1:0] pick();
      case ($urandom_range(0, 5))
         0: return 32'h80000000;
         1: return 32'hFFFFFFFF;
         2: return W'($urandom_range(0, 20));
         3: return -W'($urandom_range(1, 20));
         4: return W'($urandom_range(0, 65535)) << $urandom_range(0, 16);
         default: return $urandom;
      endcase
   endfunction

   initial begin
      logic [W-1:0] c34;
      int dones, first_done, stray;
      logic c36_ok;
      Reset = 1'b0;
      al_start = 1'b0;
      al_cmd = AC_AD;
      al_A = '0;
      al_B = '0;
      repeat (3) @(posedge Clock);
      @(negedge Clock);
      check("rst_outputs", {60'(0), al_busy, al_done, al_err, 1'b0}, 64'(0));
      check("rst_C", 64'(al_C), 64'(0));
      Reset = 1'b1;

      run_op("ad_ovf", AC_AD, 32'h7FFFFFFF, 32'd1, 1'b0);
      run_op("mu_neg", AC_MU, 32'd7, -32'd6, 1'b1);
      run_op("di_neg", AC_DI, -32'd7, 32'd2, 1'b0);
      run_op("di_pos", AC_DI, 32'd100, 32'd10, 1'b1);
      run_op("di_zero", AC_DI, 32'd5, 32'd0, 1'b0);
      run_op("di_minneg1", AC_DI, 32'h80000000, 32'hFFFFFFFF, 1'b0);
      run_op("mu_ovf", AC_MU, 32'd65536, 32'd65536, 1'b0);
      run_op("mu_min", AC_MU, 32'h80000000, 32'd1, 1'b0);
      run_op("sb_ovf", AC_SB, 32'h80000000, 32'd1, 1'b0);
      run_op("unk_cmd", 3'd6, 32'd20, 32'd22, 1'b0);

      // Starts while busy and during done must be ignored; the next cycle accepts.
      @(negedge Clock);
      al_start = 1'b1; al_cmd = AC_MU; al_A = 32'd3; al_B = 32'd4;
      @(posedge Clock);
      #1 al_start = 1'b0;
      dones = 0; first_done = 0; c34 = '0; c36_ok = 1'b0;
      for (int n = 1; n <= 37; n++) begin
         @(negedge Clock);
         if (al_done) begin
            dones++;
            if (first_done == 0) first_done = n;
         end
         if (n == 34) c34 = al_C;
         if (n == 36) c36_ok = al_done && (al_C == 32'd5);
         al_start = (n == 5) || (n == 34) || (n == 35);
         al_cmd   = AC_AD;
         al_A     = (n == 35) ? 32'd2 : 32'd100;
         al_B     = 32'd3;
      end
      al_start = 1'b0;
      $display("ignore_start first_done=%0d dones=%0d C34=%0h", first_done, dones, c34);
      check("ign_first_done", 64'(first_done), 64'(34));
      check("ign_C", 64'(c34), 64'(12));
      check("ign_dones", 64'(dones), 64'(2));
      check("ign_accept35", 64'(c36_ok), 64'(1));

      // Reset mid-multiply discards the pending result.
      @(negedge Clock);
      al_start = 1'b1; al_cmd = AC_MU; al_A = 32'd9; al_B = 32'd9;
      @(posedge Clock);
      #1 al_start = 1'b0;
      stray = 0;
      for (int n = 1; n <= 40; n++) begin
         @(negedge Clock);
         if (al_done) stray++;
         if (n == 9) check("rst_mid_busy_before", 64'(al_busy), 64'(1));
         if (n == 10) Reset = 1'b0;
         if (n == 11) begin
            check("rst_mid_busy", 64'(al_busy), 64'(0));
            check("rst_mid_C", 64'(al_C), 64'(0));
            check("rst_mid_err", 64'(al_err), 64'(0));
            Reset = 1'b1;
         end
      end
      $display("reset_mid stray_dones=%0d", stray);
      check("rst_mid_no_done", 64'(stray), 64'(0));

      for (int i = 0; i < 40; i++) begin
         logic [AC_N-1:0] rc;
         rc = AC_N'($urandom_range(0, 3));
         run_op($sformatf("rnd%0d", i), rc, pick(), pick(), i[0]);
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
